// File: rtl/rand_dir_sampler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rand_dir_sampler_pkg
// Purpose  : Shared fixed-point types and helpers for the random-direction
//            sampler and other consumers of the upstream random word.
//            fixed_real is signed two's complement Q32.32.
// Revision : 1.0 - initial release
// ============================================================================
package rand_dir_sampler_pkg;

    typedef logic signed [63:0] fixed_real;

    // Packed so that {z,y,x} maps onto a flat 192-bit bus with z in the MSBs.
    typedef struct packed {
        fixed_real z;
        fixed_real y;
        fixed_real x;
    } vector;

    localparam int        FRAC_BITS = 32;
    localparam fixed_real FIXED_ONE = 64'h0000_0001_0000_0000;

    typedef enum logic [2:0] {
        S_X    = 3'd0,
        S_Y    = 3'd1,
        S_Z    = 3'd2,
        S_SQ   = 3'd3,
        S_CMP  = 3'd4,
        S_HOLD = 3'd5
    } state_t;

    // Bit 32 is the sign of the unit component; bits [31:0] are the fraction,
    // so the result spans [-1.0, 1.0).
    function automatic fixed_real to_unit_comp(input logic [32:0] r);
        return {{31{r[32]}}, r};
    endfunction

endpackage : rand_dir_sampler_pkg
`default_nettype wire

// File: rtl/rand_dir_len2.sv
`default_nettype none
// ============================================================================
// Module   : rand_dir_len2
// Purpose  : Registered squares of three 33-bit signed unit components and
//            the combinational squared length with its accept decision.
// Ports    : Clk, Reset_n  - clock, async active-low reset
//            load          - capture the three squares this cycle
//            x, y, z       - signed components, Q1.32 (range [-1.0, 1.0))
//            len2          - sum of squares, unsigned Q4.64
//            accept        - 0 < len2 < 1.0
// Revision : 1.0 - initial release
// ============================================================================
module rand_dir_len2 (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               load,
    input  logic signed [32:0] x,
    input  logic signed [32:0] y,
    input  logic signed [32:0] z,
    output logic        [67:0] len2,
    output logic               accept
);

    logic signed [65:0] w_px;
    logic signed [65:0] w_py;
    logic signed [65:0] w_pz;
    logic        [65:0] r_sx;
    logic        [65:0] r_sy;
    logic        [65:0] r_sz;

    // Squares are never negative, so the 66-bit signed product is reused
    // as an unsigned Q2.64 value (max 2^64 for a -1.0 component).
    assign w_px = 66'(x) * 66'(x);
    assign w_py = 66'(y) * 66'(y);
    assign w_pz = 66'(z) * 66'(z);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sx <= '0;
            r_sy <= '0;
            r_sz <= '0;
        end else if (load) begin
            r_sx <= w_px;
            r_sy <= w_py;
            r_sz <= w_pz;
        end
    end

    assign len2   = 68'(r_sx) + 68'(r_sy) + 68'(r_sz);
    // Below 1.0 means nothing at or above bit 64; a zero vector has no direction.
    assign accept = (len2[67:64] == 4'd0) && (len2 != 68'd0);

endmodule : rand_dir_len2
`default_nettype wire

// File: rtl/rand_dir_sampler.sv
`default_nettype none
// ============================================================================
// Module   : rand_dir_sampler
// Purpose  : Rejection sampler producing uniformly distributed direction
//            vectors strictly inside the unit sphere from a 64-bit random
//            word per cycle. After MAX_TRIES consecutive rejects the fixed
//            vector (0,0,1.0) is emitted, flagged by dir_fallback.
// Ports    : Clk, Reset_n   - clock, async active-low reset
//            en             - gates component capture (S_X..S_Z)
//            random         - random word, low 33 bits used
//            dir            - {z,y,x}, signed Q32.32 each
//            dir_valid      - handshake valid, dir_ready - handshake ready
//            dir_fallback   - dir is the fallback vector
//            reject_total   - saturating count of rejected attempts
// Revision : 1.0 - initial release
// ============================================================================
module rand_dir_sampler
    import rand_dir_sampler_pkg::*;
#(
    parameter int MAX_TRIES = 8,
    parameter int STAT_W    = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              en,
    input  logic [63:0]       random,
    output logic [191:0]      dir,
    output logic              dir_valid,
    input  logic              dir_ready,
    output logic              dir_fallback,
    output logic [STAT_W-1:0] reject_total
);

    localparam logic [7:0] c_last_try = 8'(MAX_TRIES - 1);

    state_t            r_state;
    state_t            w_next;
    fixed_real         r_x;
    fixed_real         r_y;
    fixed_real         r_z;
    vector             r_dir;
    logic              r_valid;
    logic              r_fallback;
    logic [STAT_W-1:0] r_rej;
    logic [7:0]        r_tries;
    logic [67:0]       w_len2;
    logic              w_accept;
    logic              w_last_try;
    logic              w_unused_random;

    // Only the low 33 bits carry a component.
    assign w_unused_random = ^random[63:33];
    assign w_last_try      = (r_tries == c_last_try);

    rand_dir_len2 u_len2 (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .load    (r_state == S_SQ),
        .x       (r_x[32:0]),
        .y       (r_y[32:0]),
        .z       (r_z[32:0]),
        .len2    (w_len2),
        .accept  (w_accept)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_X;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_X:    if (en) w_next = S_Y;
            S_Y:    if (en) w_next = S_Z;
            S_Z:    if (en) w_next = S_SQ;
            S_SQ:   w_next = S_CMP;
            S_CMP:  w_next = (w_accept || w_last_try) ? S_HOLD : S_X;
            S_HOLD: if (r_valid && dir_ready) w_next = S_X;
            default: w_next = S_X;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_x        <= '0;
            r_y        <= '0;
            r_z        <= '0;
            r_dir      <= '0;
            r_valid    <= 1'b0;
            r_fallback <= 1'b0;
            r_rej      <= '0;
            r_tries    <= '0;
        end else begin
            case (r_state)
                S_X: if (en) r_x <= to_unit_comp(random[32:0]);
                S_Y: if (en) r_y <= to_unit_comp(random[32:0]);
                S_Z: if (en) r_z <= to_unit_comp(random[32:0]);
                S_CMP: begin
                    if (w_accept) begin
                        r_dir.z    <= r_z;
                        r_dir.y    <= r_y;
                        r_dir.x    <= r_x;
                        r_fallback <= 1'b0;
                        r_valid    <= 1'b1;
                        r_tries    <= '0;
                    end else begin
                        if (r_rej != {STAT_W{1'b1}}) r_rej <= r_rej + 1'b1;
                        if (w_last_try) begin
                            r_dir.z    <= FIXED_ONE;
                            r_dir.y    <= '0;
                            r_dir.x    <= '0;
                            r_fallback <= 1'b1;
                            r_valid    <= 1'b1;
                            r_tries    <= '0;
                        end else begin
                            r_tries <= r_tries + 8'd1;
                        end
                    end
                end
                S_HOLD: if (r_valid && dir_ready) r_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign dir          = r_dir;
    assign dir_valid    = r_valid;
    assign dir_fallback = r_fallback;
    assign reject_total = r_rej;

endmodule : rand_dir_sampler
`default_nettype wire
